screen_sprite_rom: RTL and testbench

//  Sprite-lookup stage of the VGA pixel path, between vga_sync (x_loc/y_loc/active) and the colour mux.
//  Per pixel it flags whether the point is inside the title-screen sprite, the game-over sprite or
//  any of ten digit glyphs 0..9, and returns each sprite's 8-bit palette index from on-chip ROM.
//  The colour mux turns indices into RGB via per-sprite palettes; this block holds no colour data.

---
 rtl/screen_sprite_rom_pkg.sv | 36 +++
 rtl/screen_sprite_rom_if.sv | 27 ++
 rtl/screen_sprite_rom_rom.sv | 20 ++
 rtl/screen_sprite_rom.sv | 130 +++++++++++++
 tb/tb_screen_sprite_rom.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/screen_sprite_rom_pkg.sv
// Shared constants, ROM identifiers and helper functions for the sprite-lookup
// stage of the VGA pixel path.
package sprite_pkg;

  localparam int IDX_W      = 8;    // palette index width
  localparam int SCREEN_W   = 640;  // visible columns
  localparam int SCREEN_H   = 480;  // visible rows
  localparam int COORD_W    = 10;   // x_loc / y_loc width
  localparam int ADDR_W     = 16;   // all ROM address arithmetic is 16-bit unsigned
  localparam int NUM_DIGITS = 10;   // digit glyphs 0..9

  typedef enum logic [1:0] {
    ROM_TITLE,
    ROM_GOVER,
    ROM_DIGITS
  } rom_id_e;

  // Built-in sprite art: one byte per address, selected by ROM identity.
  // Title art is zero at address 0, so its first pixel is transparent when
  // transparency is enabled.
  function automatic logic [IDX_W-1:0] rom_byte(rom_id_e id, logic [ADDR_W-1:0] a);
    case (id)
      ROM_TITLE: return a[7:0] ^ a[15:8];
      ROM_GOVER: return ~a[7:0] + a[15:8];
      default:   return (a[7:0] + {a[11:8], 4'h0}) ^ {4'h0, a[15:12]};
    endcase
  endfunction

  // Box test, inclusive at the origin and exclusive at origin+size.
  function automatic logic in_box(logic [ADDR_W-1:0] x, logic [ADDR_W-1:0] y,
                                  logic [ADDR_W-1:0] x0, logic [ADDR_W-1:0] y0,
                                  logic [ADDR_W-1:0] w, logic [ADDR_W-1:0] h);
    return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
  endfunction

endpackage

// File: rtl/screen_sprite_rom_if.sv
// Pixel-path interface: coordinates in from vga_sync, sprite flags and palette
// indices out to the colour mux.
interface screen_sprite_rom_if;
  import sprite_pkg::*;

  logic [COORD_W-1:0]          x_loc;
  logic [COORD_W-1:0]          y_loc;
  logic                        active;
  logic                        title_on;
  logic                        gover_on;
  logic [IDX_W-1:0]            title_idx;
  logic [IDX_W-1:0]            gover_idx;
  logic [NUM_DIGITS-1:0]       dig_on;
  logic [NUM_DIGITS*IDX_W-1:0] dig_idx;

  // Timing generator side.
  modport master (
    output x_loc, y_loc, active,
    input  title_on, gover_on, title_idx, gover_idx, dig_on, dig_idx
  );

  // Sprite-lookup side.
  modport slave (
    input  x_loc, y_loc, active,
    output title_on, gover_on, title_idx, gover_idx, dig_on, dig_idx
  );
endinterface

// File: rtl/screen_sprite_rom_rom.sv
// Synchronous 8-bit sprite ROM: data appears on the clock edge after the
// address. Contents come from the package art selected by ROM_ID.
module sprite_rom import sprite_pkg::*; #(
  parameter int      DEPTH  = 8192,
  parameter rom_id_e ROM_ID = ROM_TITLE
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  // Registered read; addresses past the end read as zero.
  // NOTE: ROM storage carries no reset; the consumer masks its output with reset-cleared flags.
  always_ff @(posedge clk) begin
    data <= (addr <= LAST) ? rom_byte(ROM_ID, addr) : '0;
  end

endmodule

// File: rtl/screen_sprite_rom.sv
// Sprite-lookup stage: per pixel, flags title / game-over / digit-glyph hits and
// returns each sprite's palette index one clock later.
// Optional macro SCREEN_SPRITE_TRANSPARENT_EN: palette index 0 reads as "no hit".
module screen_sprite_rom #(
  parameter int TITLE_X = 256,
  parameter int TITLE_Y = 100,
  parameter int GOVER_X = 256,
  parameter int GOVER_Y = 280,
  parameter int SPR_W   = 128,
  parameter int SPR_H   = 64,
  parameter int DIG_X   = 240,
  parameter int DIG_Y   = 400,
  parameter int DIG_W   = 16,
  parameter int DIG_H   = 24
) (
  input  logic                clk,
  input  logic                rst,
  screen_sprite_rom_if.slave  bus
);
  import sprite_pkg::*;

`ifdef SCREEN_SPRITE_TRANSPARENT_EN
  localparam bit TRANSPARENT = 1'b1;
`else
  localparam bit TRANSPARENT = 1'b0;
`endif

  localparam int K_W = $clog2(NUM_DIGITS);

  localparam logic [ADDR_W-1:0] TX    = ADDR_W'(TITLE_X);
  localparam logic [ADDR_W-1:0] TY    = ADDR_W'(TITLE_Y);
  localparam logic [ADDR_W-1:0] GX    = ADDR_W'(GOVER_X);
  localparam logic [ADDR_W-1:0] GY    = ADDR_W'(GOVER_Y);
  localparam logic [ADDR_W-1:0] SW    = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] SH    = ADDR_W'(SPR_H);
  localparam logic [ADDR_W-1:0] DX    = ADDR_W'(DIG_X);
  localparam logic [ADDR_W-1:0] DY    = ADDR_W'(DIG_Y);
  localparam logic [ADDR_W-1:0] DW    = ADDR_W'(DIG_W);
  localparam logic [ADDR_W-1:0] DH    = ADDR_W'(DIG_H);
  localparam logic [ADDR_W-1:0] ROW_W = ADDR_W'(NUM_DIGITS * DIG_W);
  localparam logic [ADDR_W-1:0] GLYPH = ADDR_W'(DIG_W * DIG_H);

  logic [ADDR_W-1:0] x, y;
  logic              title_hit, gover_hit, dig_hit;
  logic [ADDR_W-1:0] title_addr, gover_addr, dig_addr, dig_rel_x;
  logic [K_W-1:0]    dig_k;

  logic              title_hit_q, gover_hit_q, dig_hit_q;
  logic [K_W-1:0]    dig_k_q;
  logic [IDX_W-1:0]  title_q, gover_q, dig_q;

  logic                        title_show, gover_show, dig_show;
  logic [NUM_DIGITS-1:0]       dig_on;
  logic [NUM_DIGITS*IDX_W-1:0] dig_idx;

  assign x = ADDR_W'(bus.x_loc);
  assign y = ADDR_W'(bus.y_loc);

  // Hit tests and ROM addresses; a missed box drives address 0 so no
  // out-of-box coordinate ever reaches a ROM. The digit row is one strip of
  // adjacent glyphs, so at most one glyph is hit and one digit ROM serves all.
  always_comb begin
    title_hit  = bus.active && in_box(x, y, TX, TY, SW, SH);
    gover_hit  = bus.active && in_box(x, y, GX, GY, SW, SH);
    dig_hit    = bus.active && in_box(x, y, DX, DY, ROW_W, DH);
    dig_rel_x  = x - DX;
    dig_k      = K_W'(dig_rel_x / DW);
    title_addr = title_hit ? (y - TY) * SW + (x - TX) : '0;
    gover_addr = gover_hit ? (y - GY) * SW + (x - GX) : '0;
    dig_addr   = dig_hit ? ADDR_W'(dig_k) * GLYPH + (y - DY) * DW + dig_rel_x % DW : '0;
  end

  sprite_rom #(.DEPTH(SPR_W * SPR_H), .ROM_ID(ROM_TITLE)) u_title_rom (
    .clk  (clk),
    .addr (title_addr),
    .data (title_q)
  );

  sprite_rom #(.DEPTH(SPR_W * SPR_H), .ROM_ID(ROM_GOVER)) u_gover_rom (
    .clk  (clk),
    .addr (gover_addr),
    .data (gover_q)
  );

  sprite_rom #(.DEPTH(NUM_DIGITS * DIG_W * DIG_H), .ROM_ID(ROM_DIGITS)) u_digit_rom (
    .clk  (clk),
    .addr (dig_addr),
    .data (dig_q)
  );

  // Hit flags registered on the same edge the ROMs capture their reads.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      title_hit_q <= 1'b0;
      gover_hit_q <= 1'b0;
      dig_hit_q   <= 1'b0;
      dig_k_q     <= '0;
    end else begin
      title_hit_q <= title_hit;
      gover_hit_q <= gover_hit;
      dig_hit_q   <= dig_hit;
      dig_k_q     <= dig_k;
    end
  end

  // Mask ROM data with the registered hits so a miss never shows stale bytes.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    title_show = title_hit_q && (!TRANSPARENT || title_q != '0);
    gover_show = gover_hit_q && (!TRANSPARENT || gover_q != '0);
    dig_show   = dig_hit_q && (!TRANSPARENT || dig_q != '0);
    dig_on     = '0;
    dig_idx    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_show && dig_k_q == K_W'(k)) begin
        dig_on[k]                = 1'b1;
        dig_idx[k*IDX_W +: IDX_W] = dig_q;
      end
    end
  end

  assign bus.title_on  = title_show;
  assign bus.gover_on  = gover_show;
  assign bus.title_idx = title_show ? title_q : '0;
  assign bus.gover_idx = gover_show ? gover_q : '0;
  assign bus.dig_on    = dig_on;
  assign bus.dig_idx   = dig_idx;

endmodule

// File: tb/tb_screen_sprite_rom.sv
// Self-checking bench for screen_sprite_rom: reset behaviour, boundary vectors,
// mid-frame reset, a random pixel stream and a sprite-window sweep with hit counts.
module tb_screen_sprite_rom;
  import sprite_pkg::*;

`ifdef SCREEN_SPRITE_TRANSPARENT_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  screen_sprite_rom_if bus ();

  screen_sprite_rom dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic        t_on;
    logic [7:0]  t_idx;
    logic        g_on;
    logic [7:0]  g_idx;
    logic [9:0]  d_on;
    logic [79:0] d_idx;
    string       name;
  } exp_t;

  typedef struct {
    int         x;
    int         y;
    bit         act;
    bit         t_on;
    bit         g_on;
    logic [9:0] d_on;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string name, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference art, written arithmetically.
  function automatic int title_rom(int a);
    return (a % 256) ^ (a / 256);
  endfunction

  function automatic int gover_rom(int a);
    return (255 - a % 256 + a / 256) % 256;
  endfunction

  function automatic int digit_rom(int a);
    return (((a % 256) + ((a / 256) % 16) * 16) % 256) ^ (a / 4096);
  endfunction

  // Expected outputs for a pixel presented one clock earlier.
  function automatic exp_t model(int x, int y, bit act);
    exp_t e;
    int   v;
    e.t_on = 0; e.t_idx = 0; e.g_on = 0; e.g_idx = 0; e.d_on = 0; e.d_idx = 0;
    e.name = $sformatf("(%0d,%0d,a%0d)", x, y, act);
    if (act && x >= 256 && x < 384 && y >= 100 && y < 164) begin
      v = title_rom((y - 100) * 128 + (x - 256));
      if (!TR || v != 0) begin e.t_on = 1; e.t_idx = 8'(v); end
    end
    if (act && x >= 256 && x < 384 && y >= 280 && y < 344) begin
      v = gover_rom((y - 280) * 128 + (x - 256));
      if (!TR || v != 0) begin e.g_on = 1; e.g_idx = 8'(v); end
    end
    for (int k = 0; k < 10; k++) begin
      if (act && x >= 240 + 16 * k && x < 256 + 16 * k && y >= 400 && y < 424) begin
        v = digit_rom(k * 384 + (y - 400) * 16 + (x - 240 - 16 * k));
        if (!TR || v != 0) begin e.d_on[k] = 1; e.d_idx[8*k +: 8] = 8'(v); end
      end
    end
    return e;
  endfunction

  task automatic add(int x, int y, bit act, bit t_on, bit g_on, logic [9:0] d_on);
    vec_t v;
    v.x = x; v.y = y; v.act = act; v.t_on = t_on; v.g_on = g_on; v.d_on = d_on;
    vecs.push_back(v);
  endtask

  task automatic drive(int x, int y, bit act);
    @(negedge clk);
    bus.x_loc  = COORD_W'(x);
    bus.y_loc  = COORD_W'(y);
    bus.active = act;
  endtask

  task automatic check_zero(string tag);
    check({tag, " title_on"},  80'(bus.title_on),  80'(0));
    check({tag, " title_idx"}, 80'(bus.title_idx), 80'(0));
    check({tag, " gover_on"},  80'(bus.gover_on),  80'(0));
    check({tag, " gover_idx"}, 80'(bus.gover_idx), 80'(0));
    check({tag, " dig_on"},    80'(bus.dig_on),    80'(0));
    check({tag, " dig_idx"},   bus.dig_idx,        80'(0));
  endtask

  task automatic drain();
    repeat (8) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #2;
    end
    check("scoreboard drained", 80'(sb.size()), 80'(0));
  endtask

  // Scoreboard consumer: one expectation per clock, sampled just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, " title_on"},  80'(bus.title_on),  80'(e.t_on));
      check({e.name, " title_idx"}, 80'(bus.title_idx), 80'(e.t_idx));
      check({e.name, " gover_on"},  80'(bus.gover_on),  80'(e.g_on));
      check({e.name, " gover_idx"}, 80'(bus.gover_idx), 80'(e.g_idx));
      check({e.name, " dig_on"},    80'(bus.dig_on),    80'(e.d_on));
      check({e.name, " dig_idx"},   bus.dig_idx,        e.d_idx);
    end
  end

  initial begin
    #(40 * 80000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   row_lo[3];
    int   row_hi[3];
    int   cnt_t, cnt_g, sum_t, sum_g, sum_d;
    int   m_t, m_g, ms_t, ms_g, ms_d;
    int   cnt_d[10];
    int   m_d[10];

    // Boundary vectors: inputs plus expected hit flags; indices come from the model.
    add(256, 100, 1, !TR, 0, 10'd0);
    add(383, 163, 1, 1, 0, 10'd0);
    add(384, 163, 1, 0, 0, 10'd0);
    add(255, 100, 1, 0, 0, 10'd0);
    add(256,  99, 1, 0, 0, 10'd0);
    add(256, 164, 1, 0, 0, 10'd0);
    add(300, 120, 0, 0, 0, 10'd0);
    add(300, 120, 1, 1, 0, 10'd0);
    add(293, 410, 1, 0, 0, 10'b0000001000);
    add(256, 280, 1, 0, 1, 10'd0);
    add(383, 343, 1, 0, 1, 10'd0);
    add(384, 280, 1, 0, 0, 10'd0);
    add(256, 344, 1, 0, 0, 10'd0);
    add(240, 401, 1, 0, 0, 10'b0000000001);
    add(239, 410, 1, 0, 0, 10'd0);
    add(255, 410, 1, 0, 0, 10'b0000000001);
    add(256, 410, 1, 0, 0, 10'b0000000010);
    add(399, 423, 1, 0, 0, 10'b1000000000);
    add(400, 423, 1, 0, 0, 10'd0);
    add(250, 424, 1, 0, 0, 10'd0);
    add(639, 479, 1, 0, 0, 10'd0);
    add(0,     0, 1, 0, 0, 10'd0);
    add(293, 410, 0, 0, 0, 10'd0);

    // Reset held with a title pixel on the inputs: everything stays zero.
    bus.x_loc = 10'd300; bus.y_loc = 10'd120; bus.active = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("in reset");

    // Release: the next edge shows the title hit.
    @(negedge clk);
    rst = 1'b1;
    e = model(300, 120, 1);
    e.name = "first after reset";
    sb.push_back(e);
    drain();

    // Table vectors, back to back.
    foreach (vecs[i]) begin
      drive(vecs[i].x, vecs[i].y, vecs[i].act);
      e = model(vecs[i].x, vecs[i].y, vecs[i].act);
      e.t_on = vecs[i].t_on;
      e.g_on = vecs[i].g_on;
      e.d_on = vecs[i].d_on;
      sb.push_back(e);
    end
    drain();

    // Mid-frame reset: outputs clear asynchronously and stay clear across an edge.
    drive(300, 120, 1);
    sb.push_back(model(300, 120, 1));
    drain();
    check("pre reset title_on", 80'(bus.title_on), 80'(1));
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_zero("async reset");
    @(posedge clk);
    #1;
    check_zero("reset over edge");
    @(negedge clk);
    rst = 1'b1;
    e = model(300, 120, 1);
    e.name = "resume after reset";
    sb.push_back(e);
    drain();

    // Random pixel stream: half inside the sprite window, half anywhere.
    for (int i = 0; i < 300; i++) begin
      int  x, y;
      bit  a;
      if (i % 2 == 0) begin
        x = $urandom_range(408, 232);
        y = $urandom_range(428, 96);
      end else begin
        x = $urandom_range(SCREEN_W - 1, 0);
        y = $urandom_range(SCREEN_H - 1, 0);
      end
      a = ($urandom_range(7, 0) != 0);
      drive(x, y, a);
      sb.push_back(model(x, y, a));
    end
    drain();

    // Sweep every row and column that any sprite occupies, counting hits.
    row_lo = '{96, 276, 396};
    row_hi = '{167, 347, 427};
    cnt_t = 0; cnt_g = 0; sum_t = 0; sum_g = 0; sum_d = 0;
    m_t = 0; m_g = 0; ms_t = 0; ms_g = 0; ms_d = 0;
    for (int k = 0; k < 10; k++) begin cnt_d[k] = 0; m_d[k] = 0; end
    for (int r = 0; r < 3; r++) begin
      for (int y = row_lo[r]; y <= row_hi[r]; y++) begin
        for (int x = 232; x <= 407; x++) begin
          drive(x, y, 1);
          e = model(x, y, 1);
          m_t += int'(e.t_on); ms_t += int'(e.t_idx);
          m_g += int'(e.g_on); ms_g += int'(e.g_idx);
          for (int k = 0; k < 10; k++) begin
            m_d[k] += int'(e.d_on[k]);
            ms_d   += int'(e.d_idx[8*k +: 8]);
          end
          @(posedge clk);
          #1;
          cnt_t += int'(bus.title_on); sum_t += int'(bus.title_idx);
          cnt_g += int'(bus.gover_on); sum_g += int'(bus.gover_idx);
          for (int k = 0; k < 10; k++) begin
            cnt_d[k] += int'(bus.dig_on[k]);
            sum_d    += int'(bus.dig_idx[8*k +: 8]);
          end
        end
      end
    end
    check("sweep title_on count", 80'(cnt_t), 80'(TR ? m_t : 8192));
    check("sweep gover_on count", 80'(cnt_g), 80'(TR ? m_g : 8192));
    for (int k = 0; k < 10; k++)
      check($sformatf("sweep dig_on[%0d] count", k), 80'(cnt_d[k]), 80'(TR ? m_d[k] : 384));
    check("sweep title_idx sum", 80'(sum_t), 80'(ms_t));
    check("sweep gover_idx sum", 80'(sum_g), 80'(ms_g));
    check("sweep dig_idx sum",   80'(sum_d), 80'(ms_d));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
